stopwatch_uart_tx: RTL



---
 rtl/stopwatch_uart_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 103 ++++++++++
 rtl/stopwatch_uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/stopwatch_uart_pkg.sv
// Shared types, ASCII constants and digit helpers for the stopwatch UART reporter.
package stopwatch_uart_pkg;

    localparam int unsigned MSG_LEN = 13;

    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_DOT   = 8'h2E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    // StNext is folded into the StStop exit of the byte serialiser.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StNext
    } tx_state_t;

    function automatic logic [7:0] bin2bcd(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(value / 7'd10);
        ones = 4'(value % 7'd10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] ascii_digit(input logic [3:0] digit);
        return CH_ZERO + {4'h0, digit};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; accepts the next byte on the final stop-bit cycle for gapless output.
module uart_tx_byte
    import stopwatch_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    tx_state_t       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            bit_end;

    assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                cnt_d   = '0;
                tx_d    = 1'b1;
                if (start_i) begin
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            // Data is latched only when leaving START, so the caller's byte mux
            // may settle during the start bit.
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    shift_d = data_i;
                    bit_d   = 3'd0;
                    tx_d    = data_i[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    ready_o = 1'b1;
                    if (start_i) begin
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/stopwatch_uart_tx.sv
// Snapshots the stopwatch time on send and streams "HH:MM:SS.CC\r\n" through the serialiser.
module stopwatch_uart_tx
    import stopwatch_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       send_i,
    input  logic [5:0] hours_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    input  logic [6:0] milliseconds_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] idx_q, idx_d;
    logic [5:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic [6:0] cs_q, cs_d;

    logic       byte_start;
    logic       byte_ready;
    logic [7:0] byte_data;
    logic [7:0] hr_bcd, mn_bcd, sc_bcd, cs_bcd;

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        idx_d      = idx_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        cs_d       = cs_q;
        byte_start = 1'b0;
        if (!busy_q) begin
            if (send_i) begin
                busy_d     = 1'b1;
                idx_d      = 4'd0;
                hours_d    = hours_i;
                minutes_d  = minutes_i;
                seconds_d  = seconds_i;
                cs_d       = (milliseconds_i > 7'd99) ? 7'd99 : milliseconds_i;
                byte_start = 1'b1;
            end
        end else if (byte_ready) begin
            if (idx_q < 4'(MSG_LEN - 1)) begin
                idx_d      = idx_q + 4'd1;
                byte_start = 1'b1;
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    assign hr_bcd = bin2bcd({1'b0, hours_q});
    assign mn_bcd = bin2bcd({1'b0, minutes_q});
    assign sc_bcd = bin2bcd({1'b0, seconds_q});
    assign cs_bcd = bin2bcd(cs_q);

    always_comb begin
        byte_data = CH_LF;
        case (idx_q)
            4'd0:       byte_data = ascii_digit(hr_bcd[7:4]);
            4'd1:       byte_data = ascii_digit(hr_bcd[3:0]);
            4'd2, 4'd5: byte_data = CH_COLON;
            4'd3:       byte_data = ascii_digit(mn_bcd[7:4]);
            4'd4:       byte_data = ascii_digit(mn_bcd[3:0]);
            4'd6:       byte_data = ascii_digit(sc_bcd[7:4]);
            4'd7:       byte_data = ascii_digit(sc_bcd[3:0]);
            4'd8:       byte_data = CH_DOT;
            4'd9:       byte_data = ascii_digit(cs_bcd[7:4]);
            4'd10:      byte_data = ascii_digit(cs_bcd[3:0]);
            4'd11:      byte_data = CH_CR;
            default:    byte_data = CH_LF;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
            hours_q   <= '0;
            minutes_q <= '0;
            seconds_q <= '0;
            cs_q      <= '0;
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            idx_q     <= idx_d;
            hours_q   <= hours_d;
            minutes_q <= minutes_d;
            seconds_q <= seconds_d;
            cs_q      <= cs_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .start_i(byte_start),
        .data_i (byte_data),
        .tx_o   (tx_o),
        .ready_o(byte_ready)
    );

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule
